// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus multi-cycle shifts (logical, arithmetic, rotate, serial fill).
// Optional feature macro: USR_ROTATE_EN enables rotate in mode 10; otherwise mode 10 acts as logical.
module univ_shift_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             sout_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             dir_reg;
    logic [1:0]       mode_reg;

    logic             fill_bit;
    logic             depart_bit;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;

    // Bit entering the vacated position, chosen from the latched controls.
    always_comb begin
        fill_bit = 1'b0;
        case (mode_reg)
            2'b01:   fill_bit = dir_reg & data_reg[WIDTH-1];
`ifdef USR_ROTATE_EN
            2'b10:   fill_bit = dir_reg ? data_reg[0] : data_reg[WIDTH-1];
`endif
            2'b11:   fill_bit = sin;
            default: fill_bit = 1'b0;
        endcase
    end

    assign depart_bit = dir_reg ? data_reg[0] : data_reg[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shl_next[gi] = fill_bit;
            end else begin : g_lsb_n
                assign shl_next[gi] = data_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_next[gi] = fill_bit;
            end else begin : g_msb_n
                assign shr_next[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            sout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            mode_reg  <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (ld) begin
                        data_reg <= in;
                    end else if (start) begin
                        dir_reg  <= dir;
                        mode_reg <= mode;
                        cnt_reg  <= amount;
                        if (amount != '0) begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    data_reg <= dir_reg ? shr_next : shl_next;
                    sout_reg <= depart_bit;
                    cnt_reg  <= cnt_reg - 1'b1;
                    // The edge carrying the final shift also leaves SHIFT.
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = data_reg;
    assign sout = sout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=16, CNT_W=5): directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_univ_shift_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        sin = 1'b0;
    logic [4:0]  amount = 5'd0;
    logic [15:0] out;
    logic        sout;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_v = 16'h0000;
    logic        m_s = 1'b0;
    logic [15:0] rot_exp;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ld(ld), .in(in), .start(start), .dir(dir),
        .mode(mode), .sin(sin), .amount(amount), .out(out), .sout(sout),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One single-bit shift computed arithmetically; returns {departing bit, new value}.
    function automatic logic [16:0] mshift(input logic [15:0] v, input logic d,
                                           input logic [1:0] m, input logic s);
        int unsigned x, dep, fill, res;
        x    = v;
        dep  = d ? (x % 2) : (x / 32768);
        case (m)
            2'd0: fill = 0;
            2'd1: fill = d ? (x / 32768) : 0;
`ifdef USR_ROTATE_EN
            2'd2: fill = dep;
`else
            2'd2: fill = 0;
`endif
            default: fill = s;
        endcase
        res = d ? (x / 2 + fill * 32768) : ((x * 2) % 65536 + fill);
        return {1'(dep), 16'(res)};
    endfunction

    task automatic do_load(input logic [15:0] v, input logic with_start);
        @(negedge clk);
        ld = 1'b1; in = v; start = with_start; dir = 1'($urandom); mode = 2'($urandom);
        amount = 5'd3;
        @(negedge clk);
        ld = 1'b0; start = 1'b0;
        m_v = v;
        check("load_out", out, m_v);
        check("load_busy", busy, 1'b0);
        check("load_done", done, 1'b0);
        if (with_start) begin
            @(negedge clk);
            check("ldprio_busy", busy, 1'b0);
            check("ldprio_done", done, 1'b0);
            check("ldprio_out", out, m_v);
        end
    endtask

    task automatic run_op(input logic d, input logic [1:0] m, input int n,
                          input logic rnd_sin, input logic sin_val, input logic noise);
        @(negedge clk);
        start = 1'b1; ld = 1'b0; dir = d; mode = m; amount = 5'(n); sin = sin_val;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("op_busy", busy, 1'b1);
            check("op_done_early", done, 1'b0);
            sin = rnd_sin ? 1'($urandom) : sin_val;
            if (noise) begin
                ld = 1'b1; start = 1'b1; in = 16'($urandom);
                dir = 1'($urandom); mode = 2'($urandom); amount = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            {m_s, m_v} = mshift(m_v, d, m, sin);
        end
        @(negedge clk);
        ld = 1'b0; start = 1'b0;
        check("op_done", done, 1'b1);
        check("op_busy_end", busy, 1'b0);
        check("op_out", out, m_v);
        check("op_sout", sout, m_s);
        @(negedge clk);
        check("op_done_pulse", done, 1'b0);
        check("op_idle_busy", busy, 1'b0);
        check("op_hold_out", out, m_v);
        $display("[TB] op dir=%0d mode=%0d n=%0d out=%h sout=%0d", d, m, n, out, sout);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_out", out, 16'h0000);
        check("rst_sout", sout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        do_load(16'h4B6E, 1'b0);
        check("c34_load", out, 16'h4B6E);
        run_op(1'b0, 2'b00, 1, 1'b0, 1'b0, 1'b0);
        check("c34_out", out, 16'h96DC);
        check("c34_sout", sout, 1'b0);

        run_op(1'b1, 2'b01, 4, 1'b0, 1'b0, 1'b0);
        check("c35_out", out, 16'hF96D);
        check("c35_sout", sout, 1'b1);

        do_load(16'h4B6E, 1'b0);
        run_op(1'b0, 2'b10, 4, 1'b0, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
        rot_exp = 16'hB6E4;
`else
        rot_exp = 16'hB6E0;
`endif
        check("c36_out", out, rot_exp);

        do_load(16'h0000, 1'b0);
        run_op(1'b1, 2'b11, 3, 1'b0, 1'b1, 1'b0);
        check("c37_out", out, 16'hE000);
        run_op(1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        check("c37_zero_out", out, 16'hE000);

        do_load(16'h1234, 1'b1);
        run_op(1'b1, 2'b00, 5, 1'b0, 1'b0, 1'b1);
        check("c39_busy_ld", out, 16'h0091);

        // Reset during the second shift cycle of a six-shift operation.
        do_load(16'hA5C3, 1'b0);
        @(negedge clk);
        start = 1'b1; dir = 1'b0; mode = 2'b00; amount = 5'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_v = 16'h0000; m_s = 1'b0;
        check("c38_out", out, 16'h0000);
        check("c38_sout", sout, 1'b0);
        check("c38_busy", busy, 1'b0);
        check("c38_done", done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("c38_no_done", done, 1'b0);
            check("c38_idle", busy, 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) do_load(16'($urandom), 1'($urandom));
            run_op(1'($urandom), 2'($urandom), $urandom_range(0, 20), 1'b1, 1'b0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
